adc_frame_receiver: RTL and testbench
=====================================

// Module: adc_frame_receiver
// PURPOSE
//  Downstream stage of the ADC serial link. Deserialises the 16-bit DOUT frame
//  (leading 0, ADD2..ADD0, D11..D0) clocked by SCLK while CSN is low. Checks and
//  splits each frame into channel and 12-bit sample, then queues it in a small FIFO.
//  Consumers read the FIFO over a valid/ready interface in the SCLK domain.
// PARAMETERS
//  FIFO_DEPTH  4  sample FIFO entries; power of 2, >=2
//  FIFO_AW     2  log2(FIFO_DEPTH)
//  CHECK_LEAD  1  1: a frame whose bit15 is 1 is rejected; 0: the bit is ignored
// PORTS
//  SCLK          in   1          serial clock; all logic on posedge
//  resetN        in   1          reset, synchronous, active-low
//  enable        in   1          receiver enable (SW[0] level)
//  csN           in   1          frame strobe from DINLogic; low = frame active
//  dout          in   1          ADC serial data, MSB first
//  clear_flags   in   1          1-cycle pulse; clears overflow/frame_err/short_frame
//  sample_ready  in   1          consumer accepts the head entry
//  sample_valid  out  1          FIFO not empty
//  sample_chan   out  3          channel of the head entry (ADD2..0)
//  sample_data   out  12         data of the head entry (D11..D0)
//  fifo_level    out  FIFO_AW+1  number of occupied entries
//  overflow      out  1          sticky: a good frame was dropped, FIFO full
//  frame_err     out  1          sticky: frame rejected by the lead-bit check
//  short_frame   out  1          sticky: csN rose before 16 bits were captured
// BEHAVIOUR
//  Reset (resetN=0 at posedge): FSM=IDLE, bit_cnt=0, shreg=0, FIFO emptied.
//   All outputs are 0: sample_valid, sample_chan, sample_data, fifo_level, flags.
//   Reset applied mid-frame discards the partial frame and pushes nothing.
//  FSM, one transition per posedge, evaluated only when enable=1:
//   IDLE:  csN=0 -> capture dout into shreg[0], bit_cnt=1, go to SHIFT.
//   SHIFT: csN=0 -> shreg={shreg[14:0],dout}, bit_cnt++.
//          When bit_cnt==15, this edge captures bit 16: form word={shreg[14:0],dout}.
//          Run the check and push, then go to DRAIN.
//          csN=1 -> discard the partial frame, set short_frame, go to IDLE.
//   DRAIN: ignore dout while csN=0. csN=1 -> IDLE.
//  enable=0: the FSM is forced to IDLE and any partial frame is discarded.
//   The FIFO pop path and the flags stay live.
//  Frame check: CHECK_LEAD=1 and word[15]=1 -> set frame_err, no push.
//  Push: sample_chan<=word[14:12], sample_data<=word[11:0].
//  Latency: sample_valid rises on the edge after the 16th data bit is captured.
//   There is no bypass; the write-to-read path is registered.
//  FIFO is show-ahead: outputs always show the head entry.
//   Pop when sample_valid && sample_ready at posedge.
//   The head fields are held stable while valid && !ready.
//  Full, push with no pop: drop the new sample (keep the oldest), set overflow.
//  Full, push with a pop in the same edge: both happen; level stays FIFO_DEPTH; no overflow.
//  Empty: sample_ready is ignored; level never underflows.
//  Pointers wrap modulo FIFO_DEPTH. fifo_level = wr_ptr - rd_ptr using FIFO_AW+1-bit pointers.
//  clear_flags in the same edge as a new flag event: the set wins (flag = 1).
// STRUCTURE
//  Package adc_pkg:
//   ADC_FRAME_BITS=16, ADC_DATA_BITS=12, ADC_ADDR_BITS=3.
//   typedef struct packed {logic [2:0] chan; logic [11:0] data;} adc_sample_t.
//   typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_DRAIN} rx_state_t.
//  Sub-module sample_fifo (params DEPTH, AW; element type adc_sample_t):
//   ports push, push_data, pop, head, empty, full, level.
//   adc_frame_receiver holds the FSM, the shift register, the frame check and the flags.
// TESTING
//  1 Frame 0_101_1010_0101_1100, ready=0: one edge later valid=1, chan=5,
//    data=0xA5C, level=1.
//  2 Five good frames with ready=0, DEPTH=4: level=4, overflow=1.
//    Drained samples equal frames 1-4 in order.
//  3 csN rises after 10 bits: no push, short_frame=1, level unchanged.
//    The next full frame is received correctly.
//  4 Frame with bit15=1, CHECK_LEAD=1: frame_err=1, no push.
//    clear_flags then returns frame_err to 0.
//  5 FIFO full, ready=1 held on the edge completing a new frame:
//    level stays 4, overflow=0, head advances by one.
//  6 resetN=0 for one edge mid-frame (bit 7) with level=2:
//    all outputs 0, FSM=IDLE, the next frame is captured from bit 0.

Source files
------------

// File: rtl/adc_pkg.sv
// adc_pkg
//   Shared widths, the sample record and the receiver state encoding for the
//   ADC serial-link receive path.
package adc_pkg;

  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_ADDR_BITS  = 3;

  typedef struct packed {
    logic [ADC_ADDR_BITS-1:0] chan;
    logic [ADC_DATA_BITS-1:0] data;
  } adc_sample_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DRAIN = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
//   Small show-ahead FIFO of adc_sample_t entries. head always presents the
//   oldest entry; a write into a full FIFO is only accepted when a pop happens
//   on the same edge, otherwise the new entry is dropped.
// Ports
//   SCLK, resetN   clock, synchronous active-low reset
//   push/push_data write request and entry
//   pop            read request (ignored while empty)
//   head           oldest entry
//   empty, full    occupancy status
//   level          occupied entries (AW+1 bits)
module sample_fifo
  import adc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        SCLK,
  input  logic        resetN,
  input  logic        push,
  input  adc_sample_t push_data,
  input  logic        pop,
  output adc_sample_t head,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level
);

  adc_sample_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_pop;
  logic        do_push;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge SCLK) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      // Cleared so the head fields read 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/adc_frame_receiver.sv
// adc_frame_receiver
//   Deserialises 16-bit ADC frames (lead 0, ADD2..0, D11..0, MSB first) while
//   csN is low, checks the lead bit, and queues channel/sample pairs in a
//   show-ahead FIFO read over valid/ready.
// Ports
//   SCLK, resetN    clock, synchronous active-low reset
//   enable          receiver enable; low forces the FSM idle
//   csN, dout       frame strobe (low = active) and serial data
//   clear_flags     clears the sticky flags (a same-edge set wins)
//   sample_ready    consumer accepts head entry
//   sample_valid    FIFO not empty
//   sample_chan/_data  head entry fields
//   fifo_level      occupied entries
//   overflow, frame_err, short_frame  sticky error flags
//
// state     | meaning
// ----------+------------------------------------------------------------
// RX_IDLE   | waiting for csN low; first low edge captures bit 15
// RX_SHIFT  | shifting bits 14..0; 16th bit completes the frame
// RX_DRAIN  | frame done, ignore dout until csN returns high
module adc_frame_receiver
  import adc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int CHECK_LEAD = 1
) (
  input  logic                     SCLK,
  input  logic                     resetN,
  input  logic                     enable,
  input  logic                     csN,
  input  logic                     dout,
  input  logic                     clear_flags,
  input  logic                     sample_ready,
  output logic                     sample_valid,
  output logic [ADC_ADDR_BITS-1:0] sample_chan,
  output logic [ADC_DATA_BITS-1:0] sample_data,
  output logic [FIFO_AW:0]         fifo_level,
  output logic                     overflow,
  output logic                     frame_err,
  output logic                     short_frame
);

  rx_state_t                 state;
  logic [3:0]                bit_cnt;
  logic [ADC_FRAME_BITS-2:0] shreg;
  logic [ADC_FRAME_BITS-1:0] word;
  logic                      frame_last;
  logic                      lead_bad;
  logic                      short_evt;
  logic                      push_q;
  adc_sample_t               push_word;
  adc_sample_t               fifo_head;
  logic                      fifo_empty;
  logic                      fifo_full;
  logic                      pop;
  logic                      ovf_evt;

  assign word       = {shreg, dout};
  assign frame_last = enable && (state == RX_SHIFT) && !csN &&
                      (bit_cnt == 4'(ADC_FRAME_BITS-1));
  assign lead_bad   = (CHECK_LEAD != 0) && word[ADC_FRAME_BITS-1];
  assign short_evt  = enable && (state == RX_SHIFT) && csN;

  always_ff @(posedge SCLK) begin
    if (!resetN) begin
      state     <= RX_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      // The completed word is staged one edge before the FIFO write, so
      // valid rises on the edge after the 16th bit.
      push_q <= frame_last && !lead_bad;
      if (frame_last && !lead_bad) begin
        push_word.chan <= word[14:12];
        push_word.data <= word[11:0];
      end
      if (!enable) begin
        state   <= RX_IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (!csN) begin
              shreg   <= {{(ADC_FRAME_BITS-2){1'b0}}, dout};
              bit_cnt <= 4'd1;
              state   <= RX_SHIFT;
            end
          end
          RX_SHIFT: begin
            if (csN) begin
              state   <= RX_IDLE;
              bit_cnt <= '0;
              shreg   <= '0;
            end else if (frame_last) begin
              state   <= RX_DRAIN;
              bit_cnt <= '0;
            end else begin
              shreg   <= {shreg[ADC_FRAME_BITS-3:0], dout};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          RX_DRAIN: begin
            if (csN) state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

  assign pop     = sample_ready && !fifo_empty;
  assign ovf_evt = push_q && fifo_full && !pop;

  always_ff @(posedge SCLK) begin
    if (!resetN) begin
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      overflow    <= ovf_evt                 | (overflow    && !clear_flags);
      frame_err   <= (frame_last && lead_bad) | (frame_err   && !clear_flags);
      short_frame <= short_evt               | (short_frame && !clear_flags);
    end
  end

  sample_fifo #(
    .DEPTH(FIFO_DEPTH),
    .AW   (FIFO_AW)
  ) u_fifo (
    .SCLK     (SCLK),
    .resetN   (resetN),
    .push     (push_q),
    .push_data(push_word),
    .pop      (pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level)
  );

  assign sample_valid = !fifo_empty;
  assign sample_chan  = fifo_head.chan;
  assign sample_data  = fifo_head.data;

endmodule

// File: tb/tb_adc_frame_receiver.sv
// tb_adc_frame_receiver
//   Directed bench for adc_frame_receiver: frames are driven on the falling
//   edge and outputs are checked on the falling edge, against hand-computed
//   values.
module tb_adc_frame_receiver;

  logic        SCLK;
  logic        resetN;
  logic        enable;
  logic        csN;
  logic        dout;
  logic        clear_flags;
  logic        sample_ready;
  logic        sample_valid;
  logic [2:0]  sample_chan;
  logic [11:0] sample_data;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frame_err;
  logic        short_frame;

  int n_checks = 0;
  int n_fail   = 0;

  adc_frame_receiver #(
    .FIFO_DEPTH(4),
    .FIFO_AW   (2),
    .CHECK_LEAD(1)
  ) dut (
    .SCLK        (SCLK),
    .resetN      (resetN),
    .enable      (enable),
    .csN         (csN),
    .dout        (dout),
    .clear_flags (clear_flags),
    .sample_ready(sample_ready),
    .sample_valid(sample_valid),
    .sample_chan (sample_chan),
    .sample_data (sample_data),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .frame_err   (frame_err),
    .short_frame (short_frame)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge SCLK);
    @(negedge SCLK);
  endtask

  // Drives the first n bits of w MSB first, then raises csN.
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SCLK);
      csN  = 1'b0;
      dout = w[15-i];
      @(posedge SCLK);
    end
    @(negedge SCLK);
    csN  = 1'b1;
    dout = 1'b0;
  endtask

  task automatic pop_one();
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(sample_valid), 0);
    chk({tag, "_chan"},  32'(sample_chan),  0);
    chk({tag, "_data"},  32'(sample_data),  0);
    chk({tag, "_level"}, 32'(fifo_level),   0);
    chk({tag, "_ovf"},   32'(overflow),     0);
    chk({tag, "_ferr"},  32'(frame_err),    0);
    chk({tag, "_short"}, 32'(short_frame),  0);
  endtask

  logic [11:0] exp_data [4];

  initial begin
    resetN       = 1'b0;
    enable       = 1'b1;
    csN          = 1'b1;
    dout         = 1'b0;
    clear_flags  = 1'b0;
    sample_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    resetN = 1'b1;
    tick();

    // 1: single frame 0_101_1010_0101_1100
    send_bits(16'h5A5C, 16);
    chk("t1_valid_before", 32'(sample_valid), 0);
    tick();
    chk("t1_valid", 32'(sample_valid), 1);
    chk("t1_chan",  32'(sample_chan),  5);
    chk("t1_data",  32'(sample_data),  32'hA5C);
    chk("t1_level", 32'(fifo_level),   1);
    pop_one();
    chk("t1_pop_valid", 32'(sample_valid), 0);
    chk("t1_pop_level", 32'(fifo_level),   0);

    // 2: five frames into a 4-deep FIFO, no consumer
    send_bits(16'h1123, 16);
    send_bits(16'h2456, 16);
    send_bits(16'h3789, 16);
    send_bits(16'h4ABC, 16);
    tick();
    chk("t2_level4", 32'(fifo_level), 4);
    chk("t2_no_ovf", 32'(overflow),   0);
    send_bits(16'h7DEF, 16);
    tick();
    chk("t2_level_full", 32'(fifo_level), 4);
    chk("t2_ovf",        32'(overflow),   1);
    exp_data[0] = 12'h123;
    exp_data[1] = 12'h456;
    exp_data[2] = 12'h789;
    exp_data[3] = 12'hABC;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_chan%0d", i), 32'(sample_chan), 32'(i + 1));
      chk($sformatf("t2_data%0d", i), 32'(sample_data), 32'(exp_data[i]));
      pop_one();
    end
    chk("t2_drained", 32'(fifo_level), 0);
    pop_one();
    chk("t2_no_underflow", 32'(fifo_level),   0);
    chk("t2_empty_valid",  32'(sample_valid), 0);
    pulse_clear();
    chk("t2_ovf_cleared", 32'(overflow), 0);

    // 3: short frame, with clear_flags held on the edge that sets the flag
    clear_flags = 1'b1;
    send_bits(16'h5123, 10);
    tick();
    clear_flags = 1'b0;
    chk("t3_short", 32'(short_frame), 1);
    chk("t3_level", 32'(fifo_level),  0);
    send_bits(16'h6321, 16);
    tick();
    chk("t3_next_valid", 32'(sample_valid), 1);
    chk("t3_next_chan",  32'(sample_chan),  6);
    chk("t3_next_data",  32'(sample_data),  32'h321);
    chk("t3_next_level", 32'(fifo_level),   1);
    pop_one();
    pulse_clear();
    chk("t3_short_cleared", 32'(short_frame), 0);

    // 4: lead bit set -> rejected
    send_bits(16'hC123, 16);
    chk("t4_ferr", 32'(frame_err), 1);
    tick();
    chk("t4_no_push", 32'(fifo_level), 0);
    pulse_clear();
    chk("t4_ferr_cleared", 32'(frame_err), 0);

    // 5: full FIFO, pop on the edge that writes a new frame
    send_bits(16'h0111, 16);
    send_bits(16'h0222, 16);
    send_bits(16'h0333, 16);
    send_bits(16'h0444, 16);
    tick();
    chk("t5_full", 32'(fifo_level), 4);
    send_bits(16'h0555, 16);
    sample_ready = 1'b1;
    tick();
    sample_ready = 1'b0;
    chk("t5_level", 32'(fifo_level), 4);
    chk("t5_no_ovf", 32'(overflow),  0);
    exp_data[0] = 12'h222;
    exp_data[1] = 12'h333;
    exp_data[2] = 12'h444;
    exp_data[3] = 12'h555;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t5_data%0d", i), 32'(sample_data), 32'(exp_data[i]));
      pop_one();
    end
    chk("t5_drained", 32'(fifo_level), 0);

    // 6: reset for one edge mid-frame with two entries queued
    send_bits(16'h1AAA, 16);
    send_bits(16'h2BBB, 16);
    tick();
    chk("t6_level2", 32'(fifo_level), 2);
    for (int i = 0; i < 7; i++) begin
      @(negedge SCLK);
      csN  = 1'b0;
      dout = 16'h3CCC >> (15 - i);
    end
    @(negedge SCLK);
    resetN = 1'b0;
    tick();
    chk_all_zero("t6_reset");
    resetN = 1'b1;
    csN    = 1'b1;
    dout   = 1'b0;
    send_bits(16'h4DDD, 16);
    tick();
    chk("t6_next_valid", 32'(sample_valid), 1);
    chk("t6_next_chan",  32'(sample_chan),  4);
    chk("t6_next_data",  32'(sample_data),  32'hDDD);
    chk("t6_next_level", 32'(fifo_level),   1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
